// File: rtl/cam_pkg.sv
// Shared camera / frame-buffer definitions used by the capture writer and the
// heading detector.
package cam_pkg;

    localparam int unsigned IMAGE_WIDTH_DFLT  = 320;
    localparam int unsigned IMAGE_HEIGHT_DFLT = 240;
    localparam int unsigned SYNC_STAGES_DFLT  = 2;
    localparam int unsigned CAM_BYTE_BITS     = 8;

    // One frame-buffer word, RGB444.
    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } pixel_t;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_START = 2'd1,
        ACTIVE     = 2'd2
    } capture_state_t;

endpackage

// File: rtl/cam_input_sync.sv
// Brings the asynchronous camera bus into the clk domain and produces
// single-cycle edge strobes for pclk rise, vsync fall and href fall.
module cam_input_sync
    import cam_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DFLT
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_cam_pclk,
    input  logic                     i_cam_vsync,
    input  logic                     i_cam_href,
    input  logic [CAM_BYTE_BITS-1:0] i_cam_data,
    output logic                     o_pclk_rise,
    output logic                     o_vsync,
    output logic                     o_vsync_fall,
    output logic                     o_href,
    output logic                     o_href_fall,
    output logic [CAM_BYTE_BITS-1:0] o_data
);

    logic [SYNC_STAGES-1:0]   r_pclk_sh;
    logic [SYNC_STAGES-1:0]   r_vsync_sh;
    logic [SYNC_STAGES-1:0]   r_href_sh;
    logic [CAM_BYTE_BITS-1:0] r_data_sh [SYNC_STAGES];

    logic r_pclk_d;
    logic r_vsync_d;
    logic r_href_d;
    logic r_pclk_rise;
    logic r_vsync_fall;
    logic r_href_fall;

    logic w_pclk;
    logic w_vsync;
    logic w_href;

    assign w_pclk  = r_pclk_sh[SYNC_STAGES-1];
    assign w_vsync = r_vsync_sh[SYNC_STAGES-1];
    assign w_href  = r_href_sh[SYNC_STAGES-1];

    // Data rides the same depth of pipeline as pclk so the byte stays aligned.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pclk_sh  <= '0;
            r_vsync_sh <= '0;
            r_href_sh  <= '0;
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                r_data_sh[i] <= '0;
            end
        end else begin
            r_pclk_sh    <= {r_pclk_sh[SYNC_STAGES-2:0],  i_cam_pclk};
            r_vsync_sh   <= {r_vsync_sh[SYNC_STAGES-2:0], i_cam_vsync};
            r_href_sh    <= {r_href_sh[SYNC_STAGES-2:0],  i_cam_href};
            r_data_sh[0] <= i_cam_data;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                r_data_sh[i] <= r_data_sh[i-1];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pclk_d     <= 1'b0;
            r_vsync_d    <= 1'b0;
            r_href_d     <= 1'b0;
            r_pclk_rise  <= 1'b0;
            r_vsync_fall <= 1'b0;
            r_href_fall  <= 1'b0;
        end else begin
            r_pclk_d     <= w_pclk;
            r_vsync_d    <= w_vsync;
            r_href_d     <= w_href;
            r_pclk_rise  <= w_pclk & ~r_pclk_d;
            r_vsync_fall <= ~w_vsync & r_vsync_d;
            r_href_fall  <= ~w_href & r_href_d;
        end
    end

    assign o_pclk_rise  = r_pclk_rise;
    assign o_vsync      = w_vsync;
    assign o_vsync_fall = r_vsync_fall;
    assign o_href       = w_href;
    assign o_href_fall  = r_href_fall;
    assign o_data       = r_data_sh[SYNC_STAGES-1];

endmodule

// File: rtl/frame_capture_writer.sv
// Camera-to-BRAM write side: pairs camera bytes into RGB444 pixels and writes
// them in raster order, flagging complete and aborted frames.
module frame_capture_writer
    import cam_pkg::*;
#(
    parameter int unsigned IMAGE_WIDTH  = IMAGE_WIDTH_DFLT,
    parameter int unsigned IMAGE_HEIGHT = IMAGE_HEIGHT_DFLT,
    parameter int unsigned ADDR_BITS    = $clog2(IMAGE_WIDTH * IMAGE_HEIGHT),
    parameter int unsigned SYNC_STAGES  = SYNC_STAGES_DFLT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cam_pclk,
    input  logic                     cam_vsync,
    input  logic                     cam_href,
    input  logic [CAM_BYTE_BITS-1:0] cam_data,
    output logic [ADDR_BITS-1:0]     wraddress,
    output logic [11:0]              wrdata,
    output logic                     wren,
    output logic                     frame_done,
    output logic                     short_frame,
    output logic [7:0]               frame_count
);

    localparam int unsigned TOTAL_PIXELS = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(TOTAL_PIXELS - 1);

    logic                     w_pclk_rise;
    logic                     w_vsync;
    logic                     w_vsync_fall;
    logic                     w_href;
    logic                     w_href_fall;
    logic [CAM_BYTE_BITS-1:0] w_data;

    capture_state_t r_state;
    capture_state_t w_state_nxt;

    logic [ADDR_BITS-1:0] r_count;
    logic                 r_full;
    logic                 r_phase;
    logic [3:0]           r_red;
    logic [ADDR_BITS-1:0] r_wraddress;
    pixel_t               r_wrdata;
    logic                 r_wren;
    logic                 r_frame_done;
    logic                 r_short_frame;
    logic [7:0]           r_frame_count;

    logic w_sample;
    logic w_last;
    logic w_do_write;
    logic w_latch_r;
    logic w_done;
    logic w_short;
    logic w_clear;
    logic w_phase_clr;

    cam_input_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_cam_pclk   (cam_pclk),
        .i_cam_vsync  (cam_vsync),
        .i_cam_href   (cam_href),
        .i_cam_data   (cam_data),
        .o_pclk_rise  (w_pclk_rise),
        .o_vsync      (w_vsync),
        .o_vsync_fall (w_vsync_fall),
        .o_href       (w_href),
        .o_href_fall  (w_href_fall),
        .o_data       (w_data)
    );

    assign w_sample = w_pclk_rise & w_href;
    // The final pixel write wins over a coincident vsync rise.
    assign w_last   = w_sample & r_phase & ~r_full & (r_count == LAST_ADDR);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_do_write  = 1'b0;
        w_latch_r   = 1'b0;
        w_done      = 1'b0;
        w_short     = 1'b0;
        w_clear     = 1'b0;
        w_phase_clr = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_vsync) begin
                    w_state_nxt = WAIT_START;
                end
            end
            WAIT_START: begin
                if (w_vsync_fall) begin
                    w_clear     = 1'b1;
                    w_state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                if (r_full) begin
                    w_done      = 1'b1;
                    w_state_nxt = WAIT_START;
                end else if (w_vsync && !w_last) begin
                    w_short     = 1'b1;
                    w_state_nxt = WAIT_START;
                end else begin
                    w_phase_clr = w_href_fall;
                    if (w_sample) begin
                        if (r_phase) begin
                            w_do_write = 1'b1;
                        end else begin
                            w_latch_r = 1'b1;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Byte assembly, pixel counter and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count       <= '0;
            r_full        <= 1'b0;
            r_phase       <= 1'b0;
            r_red         <= '0;
            r_wraddress   <= '0;
            r_wrdata      <= '0;
            r_wren        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_short_frame <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_wren        <= w_do_write;
            r_frame_done  <= w_done;
            r_short_frame <= w_short;
            if (w_done) begin
                r_frame_count <= r_frame_count + 8'd1;
                r_full        <= 1'b0;
            end
            if (w_clear) begin
                r_count <= '0;
                r_phase <= 1'b0;
                r_full  <= 1'b0;
            end
            if (w_phase_clr) begin
                r_phase <= 1'b0;
            end
            if (w_latch_r) begin
                r_red   <= w_data[3:0];
                r_phase <= 1'b1;
            end
            if (w_do_write) begin
                r_wraddress <= r_count;
                r_wrdata    <= pixel_t'{r: r_red, g: w_data[7:4], b: w_data[3:0]};
                r_phase     <= 1'b0;
                // Counter parks on the last address; r_full marks the frame total.
                if (w_last) begin
                    r_full <= 1'b1;
                end else begin
                    r_count <= r_count + ADDR_BITS'(1);
                end
            end
        end
    end

    assign wraddress   = r_wraddress;
    assign wrdata      = r_wrdata;
    assign wren        = r_wren;
    assign frame_done  = r_frame_done;
    assign short_frame = r_short_frame;
    assign frame_count = r_frame_count;

endmodule

// File: tb/tb_frame_capture_writer.sv
// Self-checking bench for frame_capture_writer on a reduced 8x4 frame.
module tb_frame_capture_writer;

    localparam int W     = 8;
    localparam int H     = 4;
    localparam int TOTAL = W * H;
    localparam int AB    = $clog2(TOTAL);

    logic          clk = 1'b0;
    logic          reset;
    logic          cam_pclk;
    logic          cam_vsync;
    logic          cam_href;
    logic [7:0]    cam_data;
    logic [AB-1:0] wraddress;
    logic [11:0]   wrdata;
    logic          wren;
    logic          frame_done;
    logic          short_frame;
    logic [7:0]    frame_count;

    frame_capture_writer #(
        .IMAGE_WIDTH  (W),
        .IMAGE_HEIGHT (H)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cam_pclk    (cam_pclk),
        .cam_vsync   (cam_vsync),
        .cam_href    (cam_href),
        .cam_data    (cam_data),
        .wraddress   (wraddress),
        .wrdata      (wrdata),
        .wren        (wren),
        .frame_done  (frame_done),
        .short_frame (short_frame),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Expected-event model: writes, frame_done and short_frame keyed by cycle.
    typedef struct {
        int cyc;
        int addr;
        int data;
    } wr_t;

    wr_t wq[$];
    int  dq[$];
    int  sq[$];

    bit  m_cap   = 0;
    int  m_cnt   = 0;
    bit  m_phase = 0;
    int  m_red   = 0;
    int  m_fc    = 0;
    int  last_a  = 0;
    int  last_d  = 0;
    bit  chk_en  = 0;
    int  n_wr    = 0;
    int  n_done  = 0;
    int  n_short = 0;

    wr_t e;
    bit  exp_wren;
    bit  exp_done;
    bit  exp_short;

    always @(posedge clk) begin
        #1;
        if (wren)        n_wr++;
        if (frame_done)  n_done++;
        if (short_frame) n_short++;
        if (chk_en) begin
            exp_wren = 1'b0;
            if (wq.size() > 0 && wq[0].cyc == cyc) begin
                e = wq.pop_front();
                exp_wren = 1'b1;
                last_a = e.addr;
                last_d = e.data;
            end
            exp_done = 1'b0;
            if (dq.size() > 0 && dq[0] == cyc) begin
                void'(dq.pop_front());
                exp_done = 1'b1;
                m_fc = (m_fc + 1) % 256;
            end
            exp_short = 1'b0;
            if (sq.size() > 0 && sq[0] == cyc) begin
                void'(sq.pop_front());
                exp_short = 1'b1;
            end
            chk("wren",        int'(wren),        int'(exp_wren));
            chk("wraddress",   int'(wraddress),   last_a);
            chk("wrdata",      int'(wrdata),      last_d);
            chk("frame_done",  int'(frame_done),  int'(exp_done));
            chk("short_frame", int'(short_frame), int'(exp_short));
            chk("frame_count", int'(frame_count), m_fc);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        wq.delete();
        dq.delete();
        sq.delete();
        m_cap = 0; m_cnt = 0; m_phase = 0; m_red = 0;
        m_fc = 0; last_a = 0; last_d = 0;
    endtask

    // Called at the pclk rising edge seen at the pins.
    task automatic model_sample(input logic [7:0] b);
        if (m_cap && cam_href) begin
            if (!m_phase) begin
                m_red   = int'(b) % 16;
                m_phase = 1;
            end else begin
                wq.push_back('{cyc: cyc + 4, addr: m_cnt, data: m_red * 256 + int'(b)});
                m_cnt++;
                m_phase = 0;
                if (m_cnt == TOTAL) begin
                    dq.push_back(cyc + 5);
                    m_cap = 0;
                end
            end
        end
    endtask

    task automatic vsync_rise();
        cam_vsync = 1'b1;
        if (m_cap && m_cnt < TOTAL) begin
            sq.push_back(cyc + 3);
            m_cap = 0;
        end
    endtask

    task automatic vsync_pulse();
        if (!cam_vsync) vsync_rise();
        idle(8);
        cam_vsync = 1'b0;
        m_cap = 1; m_cnt = 0; m_phase = 0;
        idle(8);
    endtask

    // One byte in a pclk = clk/4 period; data changes while pclk is low.
    task automatic byte_out(input logic [7:0] b, input bit vs_after);
        cam_data = b;
        cam_pclk = 1'b0;
        idle(2);
        cam_pclk = 1'b1;
        model_sample(b);
        @(negedge clk);
        if (vs_after) vsync_rise();
        @(negedge clk);
    endtask

    task automatic end_line();
        cam_href = 1'b0;
        cam_pclk = 1'b0;
        m_phase  = 0;
        idle(6);
    endtask

    task automatic send_line(input int nbytes, input int pat, input int seed, input bit vs_last);
        logic [7:0] b;
        cam_href = 1'b1;
        for (int i = 0; i < nbytes; i++) begin
            if (pat == 0) b = (i % 2 == 0) ? 8'h0A : 8'h5C;
            else          b = 8'(i * 29 + seed);
            byte_out(b, vs_last && (i == nbytes - 1));
        end
        end_line();
    endtask

    int base_wr;
    int base_done;
    int base_short;

    initial begin
        reset = 1'b1; cam_pclk = 1'b0; cam_vsync = 1'b0; cam_href = 1'b0; cam_data = 8'h00;
        idle(3);
        chk("rst_wraddress",   int'(wraddress),   0);
        chk("rst_wrdata",      int'(wrdata),      0);
        chk("rst_wren",        int'(wren),        0);
        chk("rst_frame_done",  int'(frame_done),  0);
        chk("rst_short_frame", int'(short_frame), 0);
        chk("rst_frame_count", int'(frame_count), 0);
        reset  = 1'b0;
        chk_en = 1'b1;
        idle(4);

        // Latency and ordering on a single short line, then an aborted frame.
        vsync_pulse();
        cam_href = 1'b1;
        byte_out(8'h03, 1'b0);
        byte_out(8'h21, 1'b0);
        byte_out(8'h0F, 1'b0);
        byte_out(8'hFF, 1'b0);
        end_line();
        chk("lat_addr",  int'(wraddress), 1);
        chk("lat_data",  int'(wrdata),    'hFFF);
        chk("lat_nwr",   n_wr,            2);
        vsync_rise();
        idle(8);
        chk("lat_short", n_short, 1);
        chk("lat_fc",    int'(frame_count), 0);

        // Full frame of (0x0A,0x5C) pairs.
        base_wr = n_wr; base_done = n_done;
        vsync_pulse();
        for (int l = 0; l < H; l++) send_line(2 * W, 0, 0, 1'b0);
        idle(4);
        chk("full_nwr",  n_wr - base_wr,     TOTAL);
        chk("full_done", n_done - base_done, 1);
        chk("full_fc",   int'(frame_count),  1);
        chk("full_addr", int'(wraddress),    TOTAL - 1);
        chk("full_data", int'(wrdata),       'hA5C);

        // Odd trailing byte dropped; next line pairs from its own first byte.
        base_wr = n_wr;
        vsync_pulse();
        send_line(2 * W + 1, 1, 1, 1'b0);
        send_line(2 * W, 1, 100, 1'b0);
        chk("odd_nwr",  n_wr - base_wr, 2 * W);
        chk("odd_addr", int'(wraddress), 2 * W - 1);
        vsync_rise();
        idle(8);

        // Short frame, then a full frame restarting at address 0.
        base_short = n_short;
        vsync_pulse();
        send_line(2 * W, 1, 7, 1'b0);
        send_line(4, 1, 55, 1'b0);
        vsync_rise();
        idle(8);
        chk("short_cnt", n_short - base_short, 1);
        chk("short_fc",  int'(frame_count),    1);
        vsync_pulse();
        for (int l = 0; l < H; l++) send_line(2 * W, 1, 3 * l + 11, 1'b0);
        chk("restart_fc", int'(frame_count), 2);

        // Overflow: one extra line after the frame total is never written.
        base_wr = n_wr; base_done = n_done; base_short = n_short;
        vsync_pulse();
        for (int l = 0; l < H + 1; l++) send_line(2 * W, 0, 0, 1'b0);
        vsync_rise();
        idle(8);
        chk("ovf_nwr",   n_wr - base_wr,       TOTAL);
        chk("ovf_done",  n_done - base_done,   1);
        chk("ovf_short", n_short - base_short, 0);
        chk("ovf_addr",  int'(wraddress),      TOTAL - 1);
        chk("ovf_fc",    int'(frame_count),    3);

        // Reset in the middle of a frame.
        vsync_pulse();
        cam_href = 1'b1;
        for (int i = 0; i < 12; i++) byte_out(8'(i * 17 + 5), 1'b0);
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #2;
        chk("mrst_wraddress", int'(wraddress),   0);
        chk("mrst_wrdata",    int'(wrdata),      0);
        chk("mrst_wren",      int'(wren),        0);
        chk("mrst_fc",        int'(frame_count), 0);
        @(negedge clk);
        reset = 1'b0;
        base_wr = n_wr; base_short = n_short;
        for (int i = 0; i < 4; i++) byte_out(8'(i + 1), 1'b0);
        end_line();
        chk("mrst_nowr", n_wr - base_wr, 0);

        // Fresh frame whose final write coincides with vsync rising.
        base_done = n_done;
        vsync_pulse();
        for (int l = 0; l < H; l++) send_line(2 * W, 1, l + 40, l == H - 1);
        idle(8);
        chk("sim_done",  n_done - base_done,   1);
        chk("sim_short", n_short - base_short, 0);
        chk("sim_fc",    int'(frame_count),    1);
        vsync_pulse();
        idle(10);

        chk("wq_empty", wq.size(), 0);
        chk("dq_empty", dq.size(), 0);
        chk("sq_empty", sq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
